pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 12 +
 rtl/pc_sequencer.sv | 55 +++++
 tb/tb_pc_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: state encoding, default PC vectors and instruction-memory bounds
package pc_sequencer_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIRECT = 2'd2} state_e;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO        = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI        = 32'h0000_6FFC;
  // A fetch address is bad when misaligned or outside instruction memory
  function automatic logic fetch_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < IMEM_LO) || (a > IMEM_HI);
  endfunction
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with boot, exception/eret redirect and stall hold; PC_ALIGN_CHECK_EN adds the fetch address-error check
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        req_exc,
  input  logic        req_eret,
  input  logic [31:0] epc,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        pc_valid,
  output logic        flush_fd,
  output logic        adel
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        run, redir_take;
  assign run        = state_q == RUN;
  assign redir_take = run && (req_exc || req_eret);
  // Next state and PC: exceptions beat eret, redirects beat stall, a missing ack holds
  always_comb begin
    state_d = state_q == BOOT ? RUN :
              redir_take ? REDIRECT :
              (state_q == REDIRECT && req_exc) ? REDIRECT : RUN;
    pc_d    = (state_q != BOOT && req_exc) ? EXC_VECTOR :
              (run && req_eret) ? epc :
              (run && !stall && imem_ack) ? npc_in : pc_q;
  end
`ifdef PC_ALIGN_CHECK_EN
  assign adel = run && fetch_bad(pc_q);
`else
  assign adel = 1'b0;
`endif
  assign pc       = pc_q;
  assign imem_req = state_q != BOOT;
  assign flush_fd = state_q == REDIRECT || redir_take;
  assign pc_valid = run && imem_ack && !stall && !adel;
  // State and PC registers; reset abandons any redirect in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a cycle reference model
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc_in = '0, epc = '0;
  logic        stall = 1'b0, req_exc = 1'b0, req_eret = 1'b0, imem_ack = 1'b0;
  logic [31:0] pc;
  logic        imem_req, pc_valid, flush_fd, adel;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc;
  int          m_boot_left, m_redir_left;
  pc_sequencer dut (
    .clk(clk), .reset(reset), .npc_in(npc_in), .stall(stall), .req_exc(req_exc),
    .req_eret(req_eret), .epc(epc), .imem_ack(imem_ack), .pc(pc), .imem_req(imem_req),
    .pc_valid(pc_valid), .flush_fd(flush_fd), .adel(adel)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic exp_adel();
`ifdef PC_ALIGN_CHECK_EN
    return m_boot_left == 0 && m_redir_left == 0 &&
           (m_pc % 4 != 0 || m_pc < 32'h3000 || m_pc > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction
  task automatic check_outputs(input string tag);
    logic running;
    running = m_boot_left == 0 && m_redir_left == 0;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, m_boot_left == 0});
    check({tag, ".flush_fd"}, {31'd0, flush_fd},
          {31'd0, m_redir_left > 0 || (running && (req_exc || req_eret))});
    check({tag, ".pc_valid"}, {31'd0, pc_valid},
          {31'd0, running && imem_ack && !stall && !exp_adel()});
    check({tag, ".adel"}, {31'd0, adel}, {31'd0, exp_adel()});
  endtask
  // One clock: apply inputs just after an edge, check before the next, then advance the model
  task automatic step(input string tag, input logic exc, input logic eret, input logic stl,
                      input logic ack, input logic [31:0] npc, input logic [31:0] ep);
    req_exc = exc; req_eret = eret; stall = stl; imem_ack = ack; npc_in = npc; epc = ep;
    #2;
    check_outputs(tag);
    @(posedge clk);
    if (m_boot_left > 0) m_boot_left--;
    else if (m_redir_left > 0) begin
      if (exc) m_pc = EXC_PC;
      else m_redir_left--;
    end else if (exc) begin
      m_pc = EXC_PC; m_redir_left = 1;
    end else if (eret) begin
      m_pc = ep; m_redir_left = 1;
    end else if (!stl && ack) m_pc = npc;
    #1;
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    m_pc = RST_PC; m_boot_left = 1; m_redir_left = 0;
    req_exc = 1'b0; req_eret = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    #1;
    check_outputs(tag);
    @(posedge clk);
    #1;
    check({tag, ".held"}, pc, RST_PC);
    reset = 1'b1;
  endtask
  initial begin
    logic [31:0] r, nv;
    @(posedge clk);
    #1;
    do_reset("rst0");
    step("boot", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_5000);
    step("run0", 1'b0, 1'b0, 1'b0, 1'b1, m_pc + 4, 32'h0);
    check("first_run_pc_seq", pc, 32'h0000_3004);
    step("run1", 1'b0, 1'b0, 1'b0, 1'b1, m_pc + 4, 32'h0);
    check("second_pc_seq", pc, 32'h0000_3008);
    step("run2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, 32'h0);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3014, 32'h0);
    check("stall_hold", pc, 32'h0000_3010);
    step("unstall", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3020, 32'h0);
    check("unstall_pc", pc, 32'h0000_3020);
    step("exc_take", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3024, 32'h0);
    check("exc_vector", pc, EXC_PC);
    step("redir", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4184, 32'h0000_3100);
    check("eret_ignored_in_redir", pc, EXC_PC);
    step("back_run", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4184, 32'h0000_3040);
    check("exc_beats_eret", pc, EXC_PC);
    step("redir_exc", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4184, 32'h0);
    step("redir_again", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4184, 32'h0);
    step("eret_take", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4188, 32'h0000_3040);
    check("eret_target", pc, 32'h0000_3040);
    req_exc = 1'b0; req_eret = 1'b0;
    #2;
    do_reset("rst_redir");
    step("boot2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h0);
    step("misalign", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3002, 32'h0);
    step("adel_cycle", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'h0);
    step("stall_mid", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_300C, 32'h0);
    do_reset("rst_stall");
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      nv = (r[3:0] == 4'd0) ? $urandom : (r[3:0] == 4'd1) ? {$urandom_range(32'h3000, 32'h6FFC)} :
           m_pc + 4;
      step("rand", r[7:4] == 4'd0, r[11:8] == 4'd0, r[13:12] == 2'd0, r[15:14] != 2'd0, nv,
           {$urandom_range(32'h0C00, 32'h1BFF), 2'b00});
      if (r[31:24] == 8'd0) do_reset("rand_rst");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
